// File: rtl/pc_branch_unit.sv
// Program-counter stage: resolves branches and jumps from ALU flags, registers PC and instret.
// Optional macro PC_MISALIGN_TRAP_EN: redirects misaligned next-PC targets to TRAP_VECTOR.
module pc_branch_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             Branch,
   input  logic             Jump,
   input  logic             JumpReg,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             signflag,
   input  logic [WIDTH-1:0] RD1,
   input  logic [WIDTH-1:0] RD2,
   input  logic [WIDTH-1:0] ImmExt,
   input  logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PCPlus4,
   output logic [WIDTH-1:0] PCTarget,
   output logic             taken,
   output logic [WIDTH-1:0] instret,
   output logic             misalign_trap
);

   // Signed compares trust the ALU sign bit alone; overflow is not corrected.
   function automatic logic branch_cond(input logic [2:0] f3, input logic z, input logic s,
                                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic c;
      c = 1'b0;
      case (f3)
         3'b000:  c = z;
         3'b001:  c = ~z;
         3'b100:  c = s;
         3'b101:  c = ~s;
         3'b110:  c = (a < b);
         3'b111:  c = (a >= b);
         default: c = 1'b0;
      endcase
      return c;
   endfunction

   logic             cond;
   logic [WIDTH-1:0] next_pc;
   logic             unused_ok;

   assign PCPlus4  = PC + WIDTH'(4);
   assign PCTarget = PC + ImmExt;
   assign cond     = branch_cond(funct3, zero, signflag, RD1, RD2);
   assign taken    = JumpReg | Jump | (Branch & cond);

   always_comb begin
      next_pc = PCPlus4;
      if (JumpReg)
         next_pc = {ALUResult[WIDTH-1:1], 1'b0};
      else if (Jump || (Branch && cond))
         next_pc = PCTarget;
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic misaligned;
   logic trap_q;

   assign misaligned    = |next_pc[1:0];
   assign misalign_trap = trap_q;
   assign unused_ok     = ALUResult[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         PC      <= RESET_VECTOR;
         instret <= '0;
         trap_q  <= 1'b0;
      end else if (!stall) begin
         PC      <= misaligned ? TRAP_VECTOR : next_pc;
         instret <= instret + WIDTH'(1);
         trap_q  <= misaligned;
      end else begin
         trap_q  <= 1'b0;
      end
   end
`else
   assign misalign_trap = 1'b0;
   assign unused_ok     = ALUResult[0] ^ (^TRAP_VECTOR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         PC      <= RESET_VECTOR;
         instret <= '0;
      end else if (!stall) begin
         PC      <= next_pc;
         instret <= instret + WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: reset, sequential fetch, branch conditions, jumps, stall, wrap, trap.
module tb_pc_branch_unit;

   logic        clk = 1'b0;
   logic        rst_n, stall, Branch, Jump, JumpReg, zero, signflag;
   logic [2:0]  funct3;
   logic [31:0] RD1, RD2, ImmExt, ALUResult;
   logic [31:0] PC, PCPlus4, PCTarget, instret;
   logic        taken, misalign_trap;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_ir;

   pc_branch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .Branch(Branch), .Jump(Jump),
      .JumpReg(JumpReg), .funct3(funct3), .zero(zero), .signflag(signflag),
      .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .ALUResult(ALUResult),
      .PC(PC), .PCPlus4(PCPlus4), .PCTarget(PCTarget), .taken(taken),
      .instret(instret), .misalign_trap(misalign_trap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; Branch = 0; Jump = 0; JumpReg = 0;
      funct3 = 3'b000; zero = 0; signflag = 0;
   endtask

   task automatic run_step(input string tag, input logic [31:0] exp_pc);
      step();
      exp_ir++;
      chk({tag, "_pc"}, PC, exp_pc);
      chk({tag, "_ir"}, instret, exp_ir);
   endtask

   initial begin
      idle();
      RD1 = 0; RD2 = 0; ImmExt = 32'h40; ALUResult = 0;
      rst_n = 0; Jump = 1; stall = 1;
      step(); step();
      chk("rst_pc", PC, 32'h0);
      chk("rst_ir", instret, 32'h0);
      chk("rst_trap", {31'b0, misalign_trap}, 32'h0);

      idle(); rst_n = 1; exp_ir = 0;
      run_step("seq1", 32'h4);
      run_step("seq2", 32'h8);
      run_step("seq3", 32'hC);
      chk("pcplus4", PCPlus4, 32'h10);
      run_step("seq4", 32'h10);

      Branch = 1; funct3 = 3'b000; zero = 1; ImmExt = 32'hFFFF_FFF8; #1;
      chk("beq_taken", {31'b0, taken}, 32'h1);
      chk("beq_target", PCTarget, 32'h8);
      run_step("beq_t", 32'h8);
      idle();
      run_step("walk1", 32'hC);
      run_step("walk2", 32'h10);
      Branch = 1; funct3 = 3'b000; zero = 0; #1;
      chk("beq_nt_taken", {31'b0, taken}, 32'h0);
      run_step("beq_nt", 32'h14);

      idle(); Jump = 1; ImmExt = 32'hC; #1;
      chk("jal_taken", {31'b0, taken}, 32'h1);
      run_step("jal", 32'h20);

      idle(); Branch = 1; funct3 = 3'b110; RD1 = 32'h1; RD2 = 32'hFFFF_FFFF; ImmExt = 32'd16; #1;
      chk("bltu_taken", {31'b0, taken}, 32'h1);
      run_step("bltu", 32'h30);
      idle(); Jump = 1; ImmExt = 32'hFFFF_FFF0;
      run_step("jal_back", 32'h20);
      idle(); Branch = 1; funct3 = 3'b111; ImmExt = 32'd16; #1;
      chk("bgeu_taken", {31'b0, taken}, 32'h0);
      run_step("bgeu", 32'h24);

      funct3 = 3'b001; zero = 0; #1;
      chk("bne", {31'b0, taken}, 32'h1);
      funct3 = 3'b100; signflag = 1; #1;
      chk("blt", {31'b0, taken}, 32'h1);
      funct3 = 3'b101; signflag = 1; #1;
      chk("bge", {31'b0, taken}, 32'h0);
      funct3 = 3'b010; zero = 1; #1;
      chk("f3_010", {31'b0, taken}, 32'h0);

      idle(); JumpReg = 1; Jump = 1; ALUResult = 32'h0000_0201; ImmExt = 32'h40; #1;
      chk("jalr_taken", {31'b0, taken}, 32'h1);
      run_step("jalr_prio", 32'h200);

      idle(); stall = 1; Jump = 1; ImmExt = 32'h80;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", PC, 32'h200);
         chk("stall_ir", instret, exp_ir);
         chk("stall_taken", {31'b0, taken}, 32'h1);
      end
      stall = 0;
      run_step("unstall", 32'h280);

      idle(); JumpReg = 1; ALUResult = 32'h0;
      run_step("to_zero", 32'h0);
      idle(); Jump = 1; ImmExt = 32'h6;
`ifdef PC_MISALIGN_TRAP_EN
      run_step("misal", 32'h100);
      chk("misal_trap", {31'b0, misalign_trap}, 32'h1);
      idle();
      run_step("misal_after", 32'h104);
      chk("misal_trap_clr", {31'b0, misalign_trap}, 32'h0);
`else
      run_step("misal", 32'h6);
      chk("misal_trap", {31'b0, misalign_trap}, 32'h0);
      idle();
      run_step("misal_after", 32'hA);
`endif

      idle(); JumpReg = 1; ALUResult = 32'hFFFF_FFFC;
      run_step("to_top", 32'hFFFF_FFFC);
      idle(); ImmExt = 32'h8; #1;
      chk("wrap_plus4", PCPlus4, 32'h0);
      chk("wrap_target", PCTarget, 32'h4);
      run_step("wrap", 32'h0);

      idle(); ImmExt = 32'h40;
      run_step("pre_rst", 32'h4);
      rst_n = 0; stall = 1; Jump = 1;
      step();
      chk("mid_rst_pc", PC, 32'h0);
      chk("mid_rst_ir", instret, 32'h0);
      rst_n = 0; stall = 0;
      step();
      chk("redir_rst_pc", PC, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter stage directly downstream of the ALU.
- Consumes the ALU `zero`/`signflag` flags and `ALUResult`, resolves branch/jump decisions and registers the next PC.
- Exports `PC`, `PCPlus4` and `PCTarget` to instruction fetch and the writeback mux.
- Also maintains an instruction-retired counter.

Parameters:
- WIDTH, 32, datapath/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap. Used only when PC_MISALIGN_TRAP_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- stall  input  1  hold PC and counter this cycle.
- Branch  input  1  current instruction is a conditional branch.
- Jump  input  1  JAL.
- JumpReg  input  1  JALR.
- funct3  input  3  branch condition select.
- zero  input  1  ALU zero flag (ALU performing RD1-RD2 for branches).
- signflag  input  1  ALU result MSB.
- RD1  input  WIDTH  rs1 value (unsigned compare).
- RD2  input  WIDTH  rs2 value (unsigned compare).
- ImmExt  input  WIDTH  sign-extended immediate.
- ALUResult  input  WIDTH  rs1+imm for JALR.
- PC  output  WIDTH  current PC, registered.
- PCPlus4  output  WIDTH  PC+4, combinational.
- PCTarget  output  WIDTH  PC+ImmExt, combinational.
- taken  output  1  redirect this cycle, combinational.
- instret  output  WIDTH  retired-instruction count, registered.
- misalign_trap  output  1  registered trap pulse (constant 0 without the optional feature).

Behaviour:
- Reset (rst_n=0 at posedge): PC<=RESET_VECTOR, instret<=0, misalign_trap<=0.
  - Reset overrides stall and everything else.
  - Reset asserted mid-stall or mid-redirect still loads RESET_VECTOR.
- Combinational outputs:
  - PCPlus4=PC+4 and PCTarget=PC+ImmExt, both mod 2^WIDTH. Wrap-around is silent: PC=32'hFFFF_FFFC gives PCPlus4=0.
- Branch condition cond, by funct3:
  - 000 BEQ: zero.
  - 001 BNE: ~zero.
  - 100 BLT: signflag.
  - 101 BGE: ~signflag.
  - 110 BLTU: RD1<RD2 unsigned.
  - 111 BGEU: RD1>=RD2 unsigned.
  - 010/011: cond=0.
  - Signed compare uses signflag only; overflow cases are not corrected. This is a documented limitation of the core.
- taken = JumpReg | Jump | (Branch & cond).
- next PC, in priority order:
  - JumpReg: {ALUResult[WIDTH-1:1],1'b0}.
  - else Jump or (Branch & cond): PCTarget.
  - else PCPlus4.
  - If JumpReg and Jump are both high, JumpReg wins.
- Per cycle:
  - If stall=1: PC, instret unchanged; taken still reflects inputs but has no effect.
  - Otherwise: PC<=next PC and instret<=instret+1. instret wraps from all-ones to 0.
- No handshake beyond stall. Latency: a redirect is visible on PC one cycle after the control inputs are presented.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - When not stalled and the chosen next PC has bits[1:0]!=0 (only possible on taken), PC<=TRAP_VECTOR.
  - misalign_trap<=1 for exactly one cycle; instret still increments.
  - With stall=1, no trap is raised and misalign_trap<=0.
- Not defined:
  - The misaligned value is loaded into PC unchanged.
  - misalign_trap tied to 0.
  - TRAP_VECTOR unused.

Test Plan:
- Hold rst_n=0 for 2 cycles with Jump=1 and stall=1 -> PC=32'h0, instret=0. After release with all controls 0 -> PC=4, 8, 12 on successive cycles.
- PC=32'h10, Branch=1, funct3=000, zero=1, ImmExt=32'hFFFF_FFF8 -> taken=1, next PC=32'h08. Same with zero=0 -> next PC=32'h14.
- PC=32'h20, Branch=1, funct3=110, RD1=1, RD2=32'hFFFF_FFFF, ImmExt=16 -> next PC=32'h30. funct3=111 with the same operands -> next PC=32'h24.
- JumpReg=1 and Jump=1 together, ALUResult=32'h0000_0201 -> next PC=32'h200 (bit0 cleared, JumpReg priority), taken=1.
- stall=1 for 3 cycles with Jump=1 -> PC and instret frozen. Deassert stall -> redirect to PCTarget in 1 cycle; instret+1.
- PC_MISALIGN_TRAP_EN defined, Jump=1, PC=0, ImmExt=6 -> PC=32'h100 and misalign_trap=1 for one cycle. Without the macro -> PC=32'h6 and misalign_trap=0.
